// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and line geometry for the I/D-cache to physical memory arbiter.
// The caches import the same constants so line geometry stays consistent.
package arb_types;
  localparam int ADDR_WIDTH  = 32;
  localparam int LINE_WIDTH  = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM_I = 2'd1,
    MEM_D = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } client_t;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundles the I-cache, D-cache and physical memory signals of the arbiter.
// The slave modport is the arbiter; the master modport is the surrounding caches and memory.
interface cache_mem_arbiter_if #(
  parameter int ADDR_WIDTH = arb_types::ADDR_WIDTH,
  parameter int LINE_WIDTH = arb_types::LINE_WIDTH
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic                  i_resp;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic                  d_resp;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_resp;
  logic [LINE_WIDTH-1:0] pmem_rdata;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_resp, pmem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_resp, pmem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter_ctrl.sv
// Arbiter FSM with round-robin pointer. load_req/grant latch a request in IDLE,
// pmem_active holds the strobe, resp_sel ({d,i}) marks the edge that captures read data.
module cache_mem_arbiter_ctrl
  import arb_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       pmem_resp,
  output client_t    grant,
  output logic       load_req,
  output logic       pmem_active,
  output logic [1:0] resp_sel
);
  arb_state_t state_q, state_d;
  client_t    last_grant_q, last_grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ICACHE;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant        = ICACHE;
    load_req     = 1'b0;
    pmem_active  = 1'b0;
    resp_sel     = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the client that did not win last time goes first.
          if (i_req && d_req) grant = (last_grant_q == ICACHE) ? DCACHE : ICACHE;
          else if (d_req)     grant = DCACHE;
          else                grant = ICACHE;
          load_req     = 1'b1;
          last_grant_d = grant;
          state_d      = (grant == DCACHE) ? MEM_D : MEM_I;
        end
      end
      MEM_I: begin
        if (pmem_resp) begin
          resp_sel = 2'b01;
          state_d  = RESP;
        end else begin
          pmem_active = 1'b1;
        end
      end
      MEM_D: begin
        if (pmem_resp) begin
          resp_sel = 2'b10;
          state_d  = RESP;
        end else begin
          pmem_active = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Serialises I-cache reads and D-cache reads/write-backs onto one line-wide memory port.
// Memory-side outputs and client responses are all registered.
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_WIDTH  = arb_types::ADDR_WIDTH,
  parameter int LINE_WIDTH  = arb_types::LINE_WIDTH,
  parameter int OFFSET_BITS = arb_types::OFFSET_BITS
) (
  input logic                clk,
  input logic                rst_n,
  cache_mem_arbiter_if.slave bus
);
  client_t    grant;
  logic       load_req, pmem_active;
  logic [1:0] resp_sel;
  logic       is_write;

  logic                  pmem_read_q, pmem_read_d;
  logic                  pmem_write_q, pmem_write_d;
  logic [ADDR_WIDTH-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
  logic                  i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  cache_mem_arbiter_ctrl u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (bus.i_read),
    .d_req       (bus.d_read | bus.d_write),
    .pmem_resp   (bus.pmem_resp),
    .grant       (grant),
    .load_req    (load_req),
    .pmem_active (pmem_active),
    .resp_sel    (resp_sel)
  );

  always_comb begin
    pmem_read_d    = 1'b0;
    pmem_write_d   = 1'b0;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    is_write       = 1'b0;
    if (load_req) begin
      // d_read together with d_write is illegal; the write wins.
      is_write       = (grant == DCACHE) && bus.d_write;
      pmem_address_d = (grant == DCACHE)
                       ? {bus.d_address[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)}
                       : {bus.i_address[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
      pmem_wdata_d   = bus.d_wdata;
      pmem_read_d    = !is_write;
      pmem_write_d   = is_write;
    end else if (pmem_active) begin
      pmem_read_d  = pmem_read_q;
      pmem_write_d = pmem_write_q;
    end
    i_resp_d  = resp_sel[0];
    d_resp_d  = resp_sel[1];
    i_rdata_d = resp_sel[0] ? bus.pmem_rdata : i_rdata_q;
    d_rdata_d = resp_sel[1] ? bus.pmem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
    end else begin
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      i_resp_q       <= i_resp_d;
      d_resp_q       <= d_resp_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
  assign bus.i_resp       = i_resp_q;
  assign bus.d_resp       = d_resp_q;
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_rdata      = d_rdata_q;

  a_no_read_write: assert property (@(posedge clk) disable iff (!rst_n)
    !(load_req && grant == DCACHE && bus.d_read && bus.d_write));
endmodule
